bp_fe_cmd_sequencer: RTL and testbench
======================================

# bp_fe_cmd_sequencer

Parametrised next-generation front-end command sequencer for the BlackParrot FE. It sits between the BE→FE command channel and the PC-gen / I-cache / I-TLB pipeline. It buffers up to `cmd_els_p` commands in an internal FIFO and decodes the head command into redirect, attaboy, I-TLB and I-cache controls. Compared with the single-entry controller, it adds a programmable post-fence drain interval, explicit illegal-opcode handling, and status outputs.

## Interface
- `vaddr_width_p`, 39: virtual address width.
- `cmd_els_p`, 2: command FIFO depth; must be ≥1.
- `fence_drain_cycles_p`, 4: idle cycles after an I-cache fence is accepted, before refetch; 0 is legal.
- `clk_i` input 1: the one clock.
- `reset_n_i` input 1: reset, asynchronous and active-low.
- `cmd_v_i` input 1: command valid.
- `cmd_opcode_i` input 4: command opcode.
  - 0 state_reset, 1 pc_redirect, 2 icache_fill_restart, 3 icache_fill_resume, 4 itlb_fill_restart, 5 itlb_fill_resume, 6 icache_fence, 7 itlb_fence, 8 attaboy, 9 wait.
  - 10–15 are illegal.
- `cmd_npc_i` input vaddr_width_p: command target PC.
- `cmd_ready_o` output 1: FIFO can accept a command (ready/valid).
- `init_done_i` input 1: PC-gen initialisation complete.
- `next_pc_i` input vaddr_width_p: PC to fetch.
- `ovr_i` input 1: predictor override.
- `fetch_exception_i` input 1: fetch exception consumed downstream.
- `icache_yumi_i` input 1: I-cache accepted the request.
- `attaboy_yumi_i` input 1: predictor consumed the attaboy.
- `redirect_v_o` output 1: PC redirect valid.
- `redirect_pc_o` output vaddr_width_p: PC to redirect to.
- `attaboy_v_o` output 1: head command is an attaboy.
- `attaboy_pc_o` output vaddr_width_p: attaboy PC.
- `icache_v_o` output 1: I-cache request valid.
- `icache_fencei_o` output 1: 1 = fence.i, 0 = fetch.
- `icache_spec_o` output 1: speculative fetch.
- `if1_we_o`, `poison_if1_o`, `poison_if2_o` output 1 each: pipeline stage write-enable and poison.
- `itlb_w_v_o`, `itlb_flush_v_o` output 1 each: I-TLB write and flush.
- `illegal_o` output 1: pulses for one cycle when an illegal opcode is dropped.
- `state_o` output 3: current state.
- `pending_o` output clog2(cmd_els_p+1): number of FIFO entries.

## Operation
- **FIFO:** registered, with no bypass.
  - Enqueue when `cmd_v_i & cmd_ready_o`.
  - `cmd_ready_o = ~full`, and is forced 0 while `reset_n_i` is low.
  - "Head" means the oldest entry; it is valid only when `pending_o > 0`.
- **Command classes:**
  - Immediate: pc_redirect, icache_fill_*, wait.
  - Complex: state_reset, itlb_fill_*, itlb_fence, icache_fence.
  - Attaboy.
  - Illegal.
- **Global rules:**
  - An illegal head is dequeued in any state, with no other effect; `illegal_o` pulses.
  - An attaboy head in any state except RESET drives `attaboy_v_o`/`attaboy_pc_o` and is dequeued on `attaboy_yumi_i`. The state does not change.
  - `redirect_v_o` = a non-attaboy, non-illegal dequeue. `redirect_pc_o` = head npc.
- **States:** RESET=0, WAIT=1, RUN=2, FENCE=3, DRAIN=4, RESUME=5.
- **RESET:**
  - Non-state_reset heads are dequeued and discarded; no redirect.
  - A state_reset head with `init_done_i` → RESUME. The command stays at head.
- **RUN / WAIT:**
  - `icache_v_o` = RUN ? ~head_complex : head_immediate.
  - `if1_we_o = icache_yumi_i & ~head_complex`.
  - An immediate head is dequeued when `if1_we_o` is high.
  - A complex head is not dequeued here. It pulses `itlb_w_v_o` (itlb_fill) or `itlb_flush_v_o` (itlb_fence) for this one cycle.
  - Next-state priority: wait dequeued → WAIT; icache_fence head → FENCE; other complex head → RESUME; `fetch_exception_i` → WAIT; `if1_we_o` → RUN; otherwise hold.
- **FENCE:**
  - `icache_v_o=1`, `icache_fencei_o=1`.
  - On `icache_yumi_i`: if `fence_drain_cycles_p>0`, load counter = fence_drain_cycles_p−1 and go → DRAIN; otherwise go → RESUME.
- **DRAIN:**
  - `icache_v_o=0`; the counter decrements each cycle.
  - Counter==0 → RESUME.
  - Drain length is exactly fence_drain_cycles_p cycles.
- **RESUME:**
  - `icache_v_o` = head valid.
  - `if1_we_o = icache_yumi_i`; the head is dequeued with redirect.
  - → RUN.
- **Control outputs:**
  - `icache_spec_o = ~(head is icache_fill_*) & ~FENCE`.
  - `poison_if1_o = fetch_exception_i`.
  - `poison_if2_o = fetch_exception_i | ovr_i | head_immediate | (~RESUME & head_complex)`.

## Timing
- **Reset assertion (async):** state=RESET, FIFO empty, counter=0.
  - Because of that, every output is 0 during and immediately after reset: `redirect_v_o`, `attaboy_v_o`, `icache_v_o`, `if1_we_o`, `itlb_*`, `illegal_o`, `pending_o`, `poison_if2_o` (with `ovr_i`/`fetch_exception_i` low).
  - `cmd_ready_o=0` during reset and 1 after.
- **Mid-operation reset:** in-flight commands and the drain count are lost.
- **Latency:** a command enqueued at cycle t is at head at t+1. An immediate redirect fires at t+1 at the earliest, if `icache_yumi_i` is high then.
- **Full FIFO:** `cmd_ready_o=0`. A dequeue in cycle t makes `cmd_ready_o=1` at t+1.
- **Read/write pointers:** wrap modulo cmd_els_p; cmd_els_p need not be a power of two.

## Test plan
- **Reset then state_reset:** reset; state_reset npc=0x80000000 with `init_done_i=1`, `icache_yumi_i=1` → RESUME, then `redirect_v_o=1` with pc 0x80000000 one cycle later → RUN.
- **Queue full:** in RUN with `icache_yumi_i=0`, enqueue 2 pc_redirects (depth 2) → `cmd_ready_o=0`, `pending_o=2`. Raise yumi → two redirects on consecutive cycles, in order.
- **Fence with drain:** icache_fence, `fence_drain_cycles_p=4` → FENCE, yumi, exactly 4 DRAIN cycles with `icache_v_o=0`, then RESUME, redirect, RUN.
- **Attaboy:** attaboy in WAIT → `attaboy_v_o=1` until yumi; state stays WAIT; no redirect.
- **Illegal and itlb_fence:** opcode 12 → dequeued, `illegal_o` for 1 cycle. itlb_fence in RUN → `itlb_flush_v_o` for 1 cycle, RESUME.
- **Fetch exception / wait:** `fetch_exception_i` in RUN → `poison_if1_o`, WAIT. A subsequent wait command → stays in WAIT.

Source files
------------

// File: rtl/bp_fe_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : bp_fe_cmd_sequencer
// Purpose  : BlackParrot front-end command sequencer. Buffers BE->FE commands
//            in a small registered FIFO and decodes the oldest (head) command
//            into PC redirect, attaboy, I-TLB and I-cache controls. Supports
//            a programmable idle interval after an I-cache fence.
// Ports    : clk_i / reset_n_i      - clock, async active-low reset
//            cmd_*_i / cmd_ready_o  - command channel (ready/valid)
//            init_done_i, next_pc_i, ovr_i, fetch_exception_i,
//            icache_yumi_i, attaboy_yumi_i - pipeline feedback
//            redirect_*_o, attaboy_*_o, icache_*_o, if1_we_o, poison_*_o,
//            itlb_*_o               - pipeline controls
//            illegal_o, state_o, pending_o - status
// Revision : 1.0 - initial release
// ============================================================================
module bp_fe_cmd_sequencer #(
   parameter int vaddr_width_p        = 39,
   parameter int cmd_els_p            = 2,
   parameter int fence_drain_cycles_p = 4
) (
   input  logic                             clk_i,
   input  logic                             reset_n_i,
   input  logic                             cmd_v_i,
   input  logic [3:0]                       cmd_opcode_i,
   input  logic [vaddr_width_p-1:0]         cmd_npc_i,
   output logic                             cmd_ready_o,
   input  logic                             init_done_i,
   input  logic [vaddr_width_p-1:0]         next_pc_i,
   input  logic                             ovr_i,
   input  logic                             fetch_exception_i,
   input  logic                             icache_yumi_i,
   input  logic                             attaboy_yumi_i,
   output logic                             redirect_v_o,
   output logic [vaddr_width_p-1:0]         redirect_pc_o,
   output logic                             attaboy_v_o,
   output logic [vaddr_width_p-1:0]         attaboy_pc_o,
   output logic                             icache_v_o,
   output logic                             icache_fencei_o,
   output logic                             icache_spec_o,
   output logic                             if1_we_o,
   output logic                             poison_if1_o,
   output logic                             poison_if2_o,
   output logic                             itlb_w_v_o,
   output logic                             itlb_flush_v_o,
   output logic                             illegal_o,
   output logic [2:0]                       state_o,
   output logic [$clog2(cmd_els_p+1)-1:0]   pending_o
);

   localparam int PTR_W = (cmd_els_p > 1) ? $clog2(cmd_els_p) : 1;
   localparam int CNT_W = $clog2(cmd_els_p + 1);
   localparam int DRN_W = (fence_drain_cycles_p > 1) ? $clog2(fence_drain_cycles_p) : 1;

   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(cmd_els_p - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(cmd_els_p);
   // Counter is loaded with N-1 so that DRAIN lasts exactly N cycles.
   localparam logic [DRN_W-1:0] DRN_LOAD =
      DRN_W'((fence_drain_cycles_p > 0) ? fence_drain_cycles_p - 1 : 0);

   localparam logic [3:0] OP_STATE_RESET   = 4'd0;
   localparam logic [3:0] OP_PC_REDIRECT   = 4'd1;
   localparam logic [3:0] OP_IC_FILL_RST   = 4'd2;
   localparam logic [3:0] OP_IC_FILL_RES   = 4'd3;
   localparam logic [3:0] OP_ITLB_FILL_RST = 4'd4;
   localparam logic [3:0] OP_ITLB_FILL_RES = 4'd5;
   localparam logic [3:0] OP_ICACHE_FENCE  = 4'd6;
   localparam logic [3:0] OP_ITLB_FENCE    = 4'd7;
   localparam logic [3:0] OP_ATTABOY       = 4'd8;
   localparam logic [3:0] OP_WAIT          = 4'd9;

   typedef enum logic [2:0] {
      S_RESET  = 3'd0,
      S_WAIT   = 3'd1,
      S_RUN    = 3'd2,
      S_FENCE  = 3'd3,
      S_DRAIN  = 3'd4,
      S_RESUME = 3'd5
   } state_e;

   state_e                    state_q, state_d;
   logic [DRN_W-1:0]          drain_q, drain_d;
   logic [PTR_W-1:0]          rptr_q, wptr_q;
   logic [CNT_W-1:0]          count_q;
   logic [3:0]                op_mem_q  [cmd_els_p];
   logic [vaddr_width_p-1:0]  npc_mem_q [cmd_els_p];

   logic                      enq, deq;
   logic                      head_v;
   logic [3:0]                head_op;
   logic [vaddr_width_p-1:0]  head_npc;
   logic                      head_immediate, head_complex, head_attaboy, head_illegal;

   // ---------------------------------------------------------------- FIFO
   assign cmd_ready_o = reset_n_i & (count_q != CNT_FULL);
   assign enq         = cmd_v_i & cmd_ready_o;
   assign head_v      = (count_q != '0);
   assign head_op     = op_mem_q[rptr_q];
   assign head_npc    = npc_mem_q[rptr_q];

   always_ff @(posedge clk_i) begin
      if (enq) begin
         op_mem_q[wptr_q]  <= cmd_opcode_i;
         npc_mem_q[wptr_q] <= cmd_npc_i;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= '0;
         state_q <= S_RESET;
         drain_q <= '0;
      end else begin
         if (enq) wptr_q <= (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
         if (deq) rptr_q <= (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
         if (enq & ~deq)      count_q <= count_q + 1'b1;
         else if (~enq & deq) count_q <= count_q - 1'b1;
         state_q <= state_d;
         drain_q <= drain_d;
      end
   end

   // ------------------------------------------------------ head decoding
   always_comb begin
      head_immediate = head_v & ((head_op == OP_PC_REDIRECT) | (head_op == OP_IC_FILL_RST) |
                                 (head_op == OP_IC_FILL_RES) | (head_op == OP_WAIT));
      head_complex   = head_v & ((head_op == OP_STATE_RESET) | (head_op == OP_ITLB_FILL_RST) |
                                 (head_op == OP_ITLB_FILL_RES) | (head_op == OP_ITLB_FENCE) |
                                 (head_op == OP_ICACHE_FENCE));
      head_attaboy   = head_v & (head_op == OP_ATTABOY);
      head_illegal   = head_v & (head_op > OP_WAIT);
   end

   // ------------------------------------------------ next state / outputs
   always_comb begin
      state_d         = state_q;
      drain_d         = drain_q;
      deq             = 1'b0;
      icache_v_o      = 1'b0;
      icache_fencei_o = 1'b0;
      if1_we_o        = 1'b0;
      itlb_w_v_o      = 1'b0;
      itlb_flush_v_o  = 1'b0;
      attaboy_v_o     = 1'b0;
      illegal_o       = 1'b0;
      redirect_v_o    = 1'b0;

      unique case (state_q)
         S_RESET: begin
            // state_reset stays at head so RESUME can issue its redirect.
            if (head_v & ~head_illegal) begin
               if (head_op == OP_STATE_RESET) begin
                  if (init_done_i) state_d = S_RESUME;
               end else begin
                  deq = 1'b1;
               end
            end
         end
         S_RUN, S_WAIT: begin
            icache_v_o     = (state_q == S_RUN) ? ~head_complex : head_immediate;
            if1_we_o       = icache_yumi_i & ~head_complex;
            itlb_w_v_o     = head_complex & ((head_op == OP_ITLB_FILL_RST) |
                                             (head_op == OP_ITLB_FILL_RES));
            itlb_flush_v_o = head_complex & (head_op == OP_ITLB_FENCE);
            if (head_immediate & if1_we_o) deq = 1'b1;
            if (head_immediate & if1_we_o & (head_op == OP_WAIT)) state_d = S_WAIT;
            else if (head_complex & (head_op == OP_ICACHE_FENCE))  state_d = S_FENCE;
            else if (head_complex)                                  state_d = S_RESUME;
            else if (fetch_exception_i)                             state_d = S_WAIT;
            else if (if1_we_o)                                      state_d = S_RUN;
         end
         S_FENCE: begin
            icache_v_o      = 1'b1;
            icache_fencei_o = 1'b1;
            if (icache_yumi_i) begin
               if (fence_drain_cycles_p > 0) begin
                  drain_d = DRN_LOAD;
                  state_d = S_DRAIN;
               end else begin
                  state_d = S_RESUME;
               end
            end
         end
         S_DRAIN: begin
            if (drain_q == '0) state_d = S_RESUME;
            else               drain_d = drain_q - 1'b1;
         end
         S_RESUME: begin
            icache_v_o = head_v;
            if1_we_o   = icache_yumi_i;
            if (icache_yumi_i) begin
               state_d = S_RUN;
               // Attaboy/illegal heads are consumed by their own rules below.
               if (head_v & ~head_attaboy & ~head_illegal) deq = 1'b1;
            end
         end
         default: state_d = S_RESET;
      endcase

      if (head_illegal) begin
         deq       = 1'b1;
         illegal_o = 1'b1;
      end
      if (head_attaboy & (state_q != S_RESET)) begin
         attaboy_v_o = 1'b1;
         if (attaboy_yumi_i) deq = 1'b1;
      end

      // Commands discarded in RESET never redirect.
      redirect_v_o = deq & ~head_attaboy & ~head_illegal & (state_q != S_RESET);
   end

   assign redirect_pc_o = head_npc;
   assign attaboy_pc_o  = head_npc;
   assign icache_spec_o = ~(head_v & ((head_op == OP_IC_FILL_RST) | (head_op == OP_IC_FILL_RES)))
                          & (state_q != S_FENCE);
   assign poison_if1_o  = fetch_exception_i;
   assign poison_if2_o  = fetch_exception_i | ovr_i | head_immediate |
                          ((state_q != S_RESUME) & head_complex);
   assign state_o       = state_q;
   assign pending_o     = count_q;

   // next_pc_i is part of the pipeline interface but does not steer sequencing.
   logic unused_ok;
   assign unused_ok = ^next_pc_i;

endmodule
`default_nettype wire

// File: tb/tb_bp_fe_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_fe_cmd_sequencer
// Purpose  : Self-checking bench for bp_fe_cmd_sequencer (default parameters:
//            39-bit VA, 2-entry FIFO, 4-cycle fence drain). A cycle-by-cycle
//            vector table covers the main flows; hand-written sequences cover
//            reset behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bp_fe_cmd_sequencer;

   localparam int VA = 39;

   logic          clk_i = 1'b0;
   logic          reset_n_i;
   logic          cmd_v_i;
   logic [3:0]    cmd_opcode_i;
   logic [VA-1:0] cmd_npc_i;
   logic          cmd_ready_o;
   logic          init_done_i;
   logic [VA-1:0] next_pc_i;
   logic          ovr_i;
   logic          fetch_exception_i;
   logic          icache_yumi_i;
   logic          attaboy_yumi_i;
   logic          redirect_v_o;
   logic [VA-1:0] redirect_pc_o;
   logic          attaboy_v_o;
   logic [VA-1:0] attaboy_pc_o;
   logic          icache_v_o;
   logic          icache_fencei_o;
   logic          icache_spec_o;
   logic          if1_we_o;
   logic          poison_if1_o;
   logic          poison_if2_o;
   logic          itlb_w_v_o;
   logic          itlb_flush_v_o;
   logic          illegal_o;
   logic [2:0]    state_o;
   logic [1:0]    pending_o;

   bp_fe_cmd_sequencer dut (
      .clk_i             (clk_i),
      .reset_n_i         (reset_n_i),
      .cmd_v_i           (cmd_v_i),
      .cmd_opcode_i      (cmd_opcode_i),
      .cmd_npc_i         (cmd_npc_i),
      .cmd_ready_o       (cmd_ready_o),
      .init_done_i       (init_done_i),
      .next_pc_i         (next_pc_i),
      .ovr_i             (ovr_i),
      .fetch_exception_i (fetch_exception_i),
      .icache_yumi_i     (icache_yumi_i),
      .attaboy_yumi_i    (attaboy_yumi_i),
      .redirect_v_o      (redirect_v_o),
      .redirect_pc_o     (redirect_pc_o),
      .attaboy_v_o       (attaboy_v_o),
      .attaboy_pc_o      (attaboy_pc_o),
      .icache_v_o        (icache_v_o),
      .icache_fencei_o   (icache_fencei_o),
      .icache_spec_o     (icache_spec_o),
      .if1_we_o          (if1_we_o),
      .poison_if1_o      (poison_if1_o),
      .poison_if2_o      (poison_if2_o),
      .itlb_w_v_o        (itlb_w_v_o),
      .itlb_flush_v_o    (itlb_flush_v_o),
      .illegal_o         (illegal_o),
      .state_o           (state_o),
      .pending_o         (pending_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      // stimulus
      logic          cv;
      logic [3:0]    op;
      logic [VA-1:0] npc;
      logic          yumi;
      logic          ayumi;
      logic          fexc;
      logic          ovr;
      // expected
      logic [2:0]    st;
      logic [1:0]    pend;
      logic          rdy;
      logic          rv;
      logic [VA-1:0] pc;   // redirect pc when rv, attaboy pc when av
      logic          iv;
      logic          fi;
      logic          av;
      logic          ill;
      logic          wv;
      logic          fv;
      logic          we;
      logic          p2;
   } vec_t;

   vec_t vecs [64];
   int   nvec   = 0;
   int   checks = 0;
   int   errors = 0;
   vec_t cur;

   task automatic chk(input string nm, input int row, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (row %0d): got %0h expected %0h", nm, row, act, exp);
      end
   endtask

   task automatic vin(input logic cv, input logic [3:0] op, input logic [VA-1:0] npc,
                      input logic yumi, input logic ayumi, input logic fexc, input logic ovr);
      cur.cv = cv; cur.op = op; cur.npc = npc; cur.yumi = yumi;
      cur.ayumi = ayumi; cur.fexc = fexc; cur.ovr = ovr;
   endtask

   task automatic vex(input logic [2:0] st, input logic [1:0] pend, input logic rdy,
                      input logic rv, input logic [VA-1:0] pc, input logic iv, input logic fi,
                      input logic av, input logic ill, input logic wv, input logic fv,
                      input logic we, input logic p2);
      cur.st = st; cur.pend = pend; cur.rdy = rdy; cur.rv = rv; cur.pc = pc; cur.iv = iv;
      cur.fi = fi; cur.av = av; cur.ill = ill; cur.wv = wv; cur.fv = fv; cur.we = we; cur.p2 = p2;
      vecs[nvec] = cur;
      nvec++;
   endtask

   task automatic drive_idle();
      cmd_v_i = 1'b0; cmd_opcode_i = 4'd0; cmd_npc_i = '0;
      icache_yumi_i = 1'b0; attaboy_yumi_i = 1'b0;
      fetch_exception_i = 1'b0; ovr_i = 1'b0;
   endtask

   initial begin
      // states: 0 RESET 1 WAIT 2 RUN 3 FENCE 4 DRAIN 5 RESUME
      //      cv op   npc            yumi ay fx ov      st pd rdy rv pc            iv fi av il wv fv we p2
      // state_reset -> RESUME -> redirect -> RUN
      vin(1, 0, 39'h80000000, 1, 0, 0, 0); vex(0, 0, 1, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0);
      vin(0, 0, 0,            1, 0, 0, 0); vex(0, 1, 1, 0, 0,            0, 0, 0, 0, 0, 0, 0, 1);
      vin(0, 0, 0,            1, 0, 0, 0); vex(5, 1, 1, 1, 39'h80000000, 1, 0, 0, 0, 0, 0, 1, 0);
      // fill FIFO with two redirects, then drain them in order
      vin(1, 1, 39'h1000,     0, 0, 0, 0); vex(2, 0, 1, 0, 0,            1, 0, 0, 0, 0, 0, 0, 0);
      vin(1, 1, 39'h2000,     0, 0, 0, 0); vex(2, 1, 1, 0, 0,            1, 0, 0, 0, 0, 0, 0, 1);
      vin(0, 0, 0,            0, 0, 0, 0); vex(2, 2, 0, 0, 0,            1, 0, 0, 0, 0, 0, 0, 1);
      vin(0, 0, 0,            1, 0, 0, 0); vex(2, 2, 0, 1, 39'h1000,     1, 0, 0, 0, 0, 0, 1, 1);
      vin(0, 0, 0,            1, 0, 0, 0); vex(2, 1, 1, 1, 39'h2000,     1, 0, 0, 0, 0, 0, 1, 1);
      // icache_fence: FENCE, 4 DRAIN cycles (yumi held high to show it is ignored), RESUME
      vin(1, 6, 39'h3000,     0, 0, 0, 0); vex(2, 0, 1, 0, 0,            1, 0, 0, 0, 0, 0, 0, 0);
      vin(0, 0, 0,            0, 0, 0, 0); vex(2, 1, 1, 0, 0,            0, 0, 0, 0, 0, 0, 0, 1);
      vin(0, 0, 0,            0, 0, 0, 0); vex(3, 1, 1, 0, 0,            1, 1, 0, 0, 0, 0, 0, 1);
      vin(0, 0, 0,            1, 0, 0, 0); vex(3, 1, 1, 0, 0,            1, 1, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) begin
         vin(0, 0, 0,         1, 0, 0, 0); vex(4, 1, 1, 0, 0,            0, 0, 0, 0, 0, 0, 0, 1);
      end
      vin(0, 0, 0,            1, 0, 0, 0); vex(5, 1, 1, 1, 39'h3000,     1, 0, 0, 0, 0, 0, 1, 0);
      // illegal opcode 12 dropped
      vin(1, 12, 0,           0, 0, 0, 0); vex(2, 0, 1, 0, 0,            1, 0, 0, 0, 0, 0, 0, 0);
      vin(0, 0, 0,            0, 0, 0, 0); vex(2, 1, 1, 0, 0,            1, 0, 0, 1, 0, 0, 0, 0);
      // itlb_fence -> flush pulse, RESUME, redirect
      vin(1, 7, 39'h4000,     0, 0, 0, 0); vex(2, 0, 1, 0, 0,            1, 0, 0, 0, 0, 0, 0, 0);
      vin(0, 0, 0,            0, 0, 0, 0); vex(2, 1, 1, 0, 0,            0, 0, 0, 0, 0, 1, 0, 1);
      vin(0, 0, 0,            0, 0, 0, 0); vex(5, 1, 1, 0, 0,            1, 0, 0, 0, 0, 0, 0, 0);
      vin(0, 0, 0,            1, 0, 0, 0); vex(5, 1, 1, 1, 39'h4000,     1, 0, 0, 0, 0, 0, 1, 0);
      // fetch exception -> WAIT; wait command keeps WAIT
      vin(0, 0, 0,            0, 0, 1, 0); vex(2, 0, 1, 0, 0,            1, 0, 0, 0, 0, 0, 0, 1);
      vin(1, 9, 39'h5000,     0, 0, 0, 0); vex(1, 0, 1, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0);
      vin(0, 0, 0,            1, 0, 0, 0); vex(1, 1, 1, 1, 39'h5000,     1, 0, 0, 0, 0, 0, 1, 1);
      // attaboy in WAIT
      vin(1, 8, 39'h6000,     0, 0, 0, 0); vex(1, 0, 1, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0);
      vin(0, 0, 0,            0, 0, 0, 0); vex(1, 1, 1, 0, 39'h6000,     0, 0, 1, 0, 0, 0, 0, 0);
      vin(0, 0, 0,            0, 1, 0, 0); vex(1, 1, 1, 0, 39'h6000,     0, 0, 1, 0, 0, 0, 0, 0);
      vin(0, 0, 0,            0, 0, 0, 0); vex(1, 0, 1, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0);
      // itlb_fill from WAIT -> write pulse, RESUME, redirect, RUN; ovr poisons if2
      vin(1, 4, 39'h7000,     0, 0, 0, 0); vex(1, 0, 1, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0);
      vin(0, 0, 0,            0, 0, 0, 0); vex(1, 1, 1, 0, 0,            0, 0, 0, 0, 1, 0, 0, 1);
      vin(0, 0, 0,            1, 0, 0, 0); vex(5, 1, 1, 1, 39'h7000,     1, 0, 0, 0, 0, 0, 1, 0);
      vin(0, 0, 0,            0, 0, 0, 1); vex(2, 0, 1, 0, 0,            1, 0, 0, 0, 0, 0, 0, 1);

      // ---------------- reset behaviour
      drive_idle();
      init_done_i = 1'b1;
      next_pc_i   = '0;
      reset_n_i   = 1'b0;
      cmd_v_i     = 1'b1;            // must not enqueue while in reset
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_ready",    -1, cmd_ready_o,  0);
      chk("rst_pending",  -1, pending_o,    0);
      chk("rst_state",    -1, state_o,      0);
      chk("rst_redirect", -1, redirect_v_o, 0);
      chk("rst_icache_v", -1, icache_v_o,   0);
      chk("rst_poison2",  -1, poison_if2_o, 0);
      chk("rst_outs",     -1, {attaboy_v_o, illegal_o, itlb_w_v_o, itlb_flush_v_o, if1_we_o}, 0);
      cmd_v_i   = 1'b0;
      reset_n_i = 1'b1;
      #1;
      chk("post_rst_ready", -1, cmd_ready_o, 1);

      // ---------------- table
      for (int r = 0; r < nvec; r++) begin
         cmd_v_i           = vecs[r].cv;
         cmd_opcode_i      = vecs[r].op;
         cmd_npc_i         = vecs[r].npc;
         icache_yumi_i     = vecs[r].yumi;
         attaboy_yumi_i    = vecs[r].ayumi;
         fetch_exception_i = vecs[r].fexc;
         ovr_i             = vecs[r].ovr;
         @(negedge clk_i);
         chk("state",      r, state_o,         vecs[r].st);
         chk("pending",    r, pending_o,       vecs[r].pend);
         chk("cmd_ready",  r, cmd_ready_o,     vecs[r].rdy);
         chk("redirect_v", r, redirect_v_o,    vecs[r].rv);
         if (vecs[r].rv) chk("redirect_pc", r, redirect_pc_o, vecs[r].pc);
         chk("icache_v",   r, icache_v_o,      vecs[r].iv);
         chk("fencei",     r, icache_fencei_o, vecs[r].fi);
         chk("attaboy_v",  r, attaboy_v_o,     vecs[r].av);
         if (vecs[r].av) chk("attaboy_pc", r, attaboy_pc_o, vecs[r].pc);
         chk("illegal",    r, illegal_o,       vecs[r].ill);
         chk("itlb_w",     r, itlb_w_v_o,      vecs[r].wv);
         chk("itlb_flush", r, itlb_flush_v_o,  vecs[r].fv);
         chk("if1_we",     r, if1_we_o,        vecs[r].we);
         chk("poison_if1", r, poison_if1_o,    vecs[r].fexc);
         chk("poison_if2", r, poison_if2_o,    vecs[r].p2);
         @(posedge clk_i);
         #1;
      end

      // ---------------- mid-operation reset loses queued commands
      drive_idle();
      cmd_v_i      = 1'b1;
      cmd_opcode_i = 4'd1;
      cmd_npc_i    = 39'h9000;
      repeat (2) begin
         @(posedge clk_i);
         #1;
      end
      cmd_v_i = 1'b0;
      chk("mid_full_pending", -2, pending_o,   2);
      chk("mid_full_ready",   -2, cmd_ready_o, 0);
      reset_n_i = 1'b0;
      #1;
      chk("mid_rst_pending", -2, pending_o,   0);
      chk("mid_rst_state",   -2, state_o,     0);
      chk("mid_rst_ready",   -2, cmd_ready_o, 0);
      @(posedge clk_i);
      #1;
      reset_n_i = 1'b1;
      #1;
      chk("mid_rel_ready",   -2, cmd_ready_o, 1);
      chk("mid_rel_pending", -2, pending_o,   0);
      chk("mid_rel_state",   -2, state_o,     0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
